// File: rtl/accum_xcel_pipe.sv
// Accumulator accelerator: streams `size` words from memory with up to
// P_MAX_INFLIGHT outstanding reads and reduces them (sum/max/min/xor).
module accum_xcel_pipe #(
  parameter int P_DATA_NBITS   = 32,
  parameter int P_ADDR_NBITS   = 16,
  parameter int P_SIZE_NBITS   = 14,
  parameter int P_MAX_INFLIGHT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [P_ADDR_NBITS-1:0] base_addr,
  input  logic [P_SIZE_NBITS-1:0] size,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic [P_ADDR_NBITS-1:0] memreq_addr,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  input  logic [P_DATA_NBITS-1:0] memresp_data,
  output logic                    result_val,
  input  logic                    result_rdy,
  output logic [P_DATA_NBITS-1:0] result
);

  localparam int CNT_W = P_SIZE_NBITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        issued_r, received_r, inflight_r;
  logic [P_ADDR_NBITS-1:0] base_r;
  logic [P_SIZE_NBITS-1:0] size_r;
  logic [1:0]              mode_r;
  logic [P_DATA_NBITS-1:0] acc_r;
  logic                    req_fire_s, resp_fire_s, last_resp_s;
  logic [CNT_W-1:0]        size_ext_s;

  function automatic logic [P_DATA_NBITS-1:0] mode_identity(input logic [1:0] m);
    case (m)
      2'b10:   mode_identity = {P_DATA_NBITS{1'b1}};
      default: mode_identity = {P_DATA_NBITS{1'b0}};
    endcase
  endfunction

  function automatic logic [P_DATA_NBITS-1:0] reduce_op(input logic [1:0] m,
                                                        input logic [P_DATA_NBITS-1:0] a,
                                                        input logic [P_DATA_NBITS-1:0] b);
    case (m)
      2'b00:   reduce_op = a + b;
      2'b01:   reduce_op = (b > a) ? b : a;
      2'b10:   reduce_op = (b < a) ? b : a;
      2'b11:   reduce_op = a ^ b;
      default: reduce_op = a;
    endcase
  endfunction

  assign size_ext_s  = {1'b0, size_r};
  assign req_fire_s  = memreq_val & memreq_rdy;
  assign resp_fire_s = (state_r == ST_RUN) & memresp_val;
  assign last_resp_s = resp_fire_s & ((received_r + CNT_W'(1)) == size_ext_s);

  // Output decode from registered state and counters only.
  always_comb begin
    busy        = 1'b0;
    memreq_val  = 1'b0;
    memreq_addr = {P_ADDR_NBITS{1'b0}};
    memresp_rdy = 1'b0;
    result_val  = 1'b0;
    result      = acc_r;
    case (state_r)
      ST_IDLE: begin
        memresp_rdy = ~rst;
      end
      ST_RUN: begin
        busy        = 1'b1;
        memresp_rdy = ~rst;
        memreq_val  = (issued_r < size_ext_s) && (inflight_r < CNT_W'(P_MAX_INFLIGHT));
        memreq_addr = base_r + P_ADDR_NBITS'({issued_r, 2'b00});
      end
      ST_DONE: begin
        busy       = 1'b1;
        result_val = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go) begin
          state_s = (size == {P_SIZE_NBITS{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_resp_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (result_rdy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: latch the request on go, then count and fold responses in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_r   <= {CNT_W{1'b0}};
      received_r <= {CNT_W{1'b0}};
      inflight_r <= {CNT_W{1'b0}};
      base_r     <= {P_ADDR_NBITS{1'b0}};
      size_r     <= {P_SIZE_NBITS{1'b0}};
      mode_r     <= 2'b00;
      acc_r      <= {P_DATA_NBITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            base_r     <= base_addr;
            size_r     <= size;
            mode_r     <= mode;
            acc_r      <= mode_identity(mode);
            issued_r   <= {CNT_W{1'b0}};
            received_r <= {CNT_W{1'b0}};
            inflight_r <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (req_fire_s) begin
            issued_r <= issued_r + CNT_W'(1);
          end
          if (resp_fire_s) begin
            acc_r      <= reduce_op(mode_r, acc_r, memresp_data);
            received_r <= received_r + CNT_W'(1);
          end
          case ({req_fire_s, resp_fire_s})
            2'b10:   inflight_r <= inflight_r + CNT_W'(1);
            2'b01:   inflight_r <= inflight_r - CNT_W'(1);
            default: inflight_r <= inflight_r;
          endcase
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_xcel_pipe.sv
// Directed bench for accum_xcel_pipe with a latency-configurable memory model.
module tb_accum_xcel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [15:0] base_addr;
  logic [13:0] size;
  logic [1:0]  mode;
  logic        busy;
  logic        memreq_val, memreq_rdy;
  logic [15:0] memreq_addr;
  logic        memresp_val, memresp_rdy;
  logic [31:0] memresp_data;
  logic        result_val, result_rdy;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:16383];
  logic [15:0] q_addr[$];
  int          q_ready[$];
  logic [15:0] addr_log[$];
  int tick = 0, lat = 1, rdy_pct = 100, resp_rand = 0;
  int max_q = 0, reqv_cycles = 0, resp_cnt = 0;

  accum_xcel_pipe #(
    .P_DATA_NBITS(32), .P_ADDR_NBITS(16), .P_SIZE_NBITS(14), .P_MAX_INFLIGHT(2)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .base_addr(base_addr), .size(size), .mode(mode),
    .busy(busy), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memreq_addr(memreq_addr), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .memresp_data(memresp_data), .result_val(result_val), .result_rdy(result_rdy),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] base, input int i, input logic [31:0] v);
    logic [15:0] a;
    a = base + 16'(4 * i);
    mem[a[15:2]] = v;
  endtask

  // Memory model: in-order responses, each ready `lat` cycles after its request.
  initial begin
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_data = 32'd0;
    forever begin
      @(negedge clk); #1;
      tick++;
      memreq_rdy = (rdy_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < rdy_pct);
      if (q_addr.size() > 0 && q_ready[0] <= tick && (resp_rand == 0 || $urandom_range(1) == 1)) begin
        memresp_val  = 1'b1;
        memresp_data = mem[q_addr[0][15:2]];
      end else begin
        memresp_val  = 1'b0;
        memresp_data = 32'd0;
      end
      #1;
      if (memreq_val) reqv_cycles++;
      if (memreq_val && memreq_rdy) begin
        addr_log.push_back(memreq_addr);
        q_addr.push_back(memreq_addr);
        q_ready.push_back(tick + lat);
      end
      if (memresp_val && memresp_rdy) begin
        void'(q_addr.pop_front());
        void'(q_ready.pop_front());
        resp_cnt++;
      end
      if (q_addr.size() > max_q) max_q = q_addr.size();
    end
  end

  task automatic run_op(input string tag, input logic [15:0] base, input logic [13:0] n,
                        input logic [1:0] m, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int k;
    int serr;
    addr_log.delete();
    max_q = 0;
    reqv_cycles = 0;
    @(negedge clk);
    go = 1'b1; base_addr = base; size = n; mode = m;
    k = 0;
    do begin
      @(negedge clk);
      go = 1'b0;
      k++;
      if (k == 1) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    end while (!result_val && k < 500);
    check_eq({tag, "_rval"}, 32'(result_val), 32'd1);
    if (exp_lat > 0) check_eq({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check_eq({tag, "_res"}, result, exp);
    serr = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (result_val !== 1'b1 || result !== exp) serr++;
    end
    if (hold > 0) check_eq({tag, "_hold"}, 32'(serr), 32'd0);
    result_rdy = 1'b1;
    @(negedge clk);
    result_rdy = 1'b0;
    check_eq({tag, "_idle"}, {30'd0, result_val, busy}, 32'd0);
    check_eq({tag, "_nreq"}, 32'(addr_log.size()), 32'(n));
    for (int i = 0; i < addr_log.size(); i++)
      check_eq({tag, "_addr"}, {16'd0, addr_log[i]}, {16'd0, base + 16'(4 * i)});
  endtask

  initial begin
    int k;
    rst = 1'b1; go = 1'b0; base_addr = 16'd0; size = 14'd0; mode = 2'b00; result_rdy = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    #3;
    check_eq("rst_outs", {26'd0, busy, memreq_val, memresp_rdy, result_val, 2'b00}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_addr", {16'd0, memreq_addr}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Sum, 1-cycle memory: result after N+2 cycles.
    load(16'h0100, 0, 32'd1); load(16'h0100, 1, 32'd2);
    load(16'h0100, 2, 32'd3); load(16'h0100, 3, 32'd4);
    run_op("sum4", 16'h0100, 14'd4, 2'b00, 32'd10, 6, 0);

    // Max/min/xor and wrapping sum on {5, 0xFFFFFFFF, 7}.
    load(16'h0200, 0, 32'd5); load(16'h0200, 1, 32'hFFFF_FFFF); load(16'h0200, 2, 32'd7);
    run_op("max", 16'h0200, 14'd3, 2'b01, 32'hFFFF_FFFF, 5, 0);
    run_op("min", 16'h0200, 14'd3, 2'b10, 32'd5, 5, 0);
    run_op("xor", 16'h0200, 14'd3, 2'b11, 32'hFFFF_FFFD, 5, 0);
    run_op("sumwrap", 16'h0200, 14'd3, 2'b00, 32'd11, 5, 0);

    // Slow memory: inflight must saturate at 2.
    for (int i = 0; i < 6; i++) load(16'h0400, i, 32'(10 + i));
    lat = 5;
    run_op("slow", 16'h0400, 14'd6, 2'b00, 32'd75, -1, 0);
    check_eq("slow_maxinflight", 32'(max_q), 32'd2);

    // Random back-pressure, address wrap, result held 10 cycles.
    load(16'hFFF8, 0, 32'd3); load(16'hFFF8, 1, 32'd9);
    load(16'hFFF8, 2, 32'd27); load(16'hFFF8, 3, 32'd81);
    lat = 2; rdy_pct = 50; resp_rand = 1;
    run_op("bp", 16'hFFF8, 14'd4, 2'b00, 32'd120, -1, 10);
    check_eq("bp_maxinflight_le2", 32'(max_q <= 2), 32'd1);
    lat = 1; rdy_pct = 100; resp_rand = 0;

    // size=0, min mode: identity on the cycle after go, no requests.
    run_op("size0", 16'h0500, 14'd0, 2'b10, 32'hFFFF_FFFF, 1, 0);
    check_eq("size0_reqv", 32'(reqv_cycles), 32'd0);

    // Reset mid-RUN, straggler responses in IDLE, then a clean run.
    for (int i = 0; i < 8; i++) load(16'h0600, i, 32'h0000_0100);
    lat = 3; resp_cnt = 0;
    @(negedge clk);
    go = 1'b1; base_addr = 16'h0600; size = 14'd8; mode = 2'b00;
    @(negedge clk);
    go = 1'b0;
    k = 0;
    while (resp_cnt < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("abort_two_resp", 32'(resp_cnt), 32'd2);
    rst = 1'b1;
    #3;
    check_eq("abort_outs", {26'd0, busy, memreq_val, memresp_rdy, result_val, 2'b00}, 32'd0);
    check_eq("abort_result", result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (q_addr.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("straggler_drained", 32'(q_addr.size()), 32'd0);
    @(negedge clk);
    check_eq("straggler_quiet", {29'd0, busy, result_val, memreq_val}, 32'd0);
    check_eq("straggler_acc", result, 32'd0);
    lat = 1;
    load(16'h0300, 0, 32'd1); load(16'h0300, 1, 32'd1); load(16'h0300, 2, 32'd1);
    run_op("after_rst", 16'h0300, 14'd3, 2'b00, 32'd3, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_xcel_pipe.md
Name: accum_xcel_pipe

Overview:
Parametrised accumulator accelerator: controller and datapath in one block.
- On a go pulse, reads `size` words from memory starting at `base_addr`, reduces them with a selectable operation, and returns the result over a valid/ready handshake.
- Successor to the single-request accumulate controller. Adds full memory val/rdy handshakes, up to P_MAX_INFLIGHT outstanding reads, reduction modes, and a back-pressured result port.
- Sits between the processor's xcel interface and the data-memory port.

Parameters:
- P_DATA_NBITS, 32, width of memory data and of the accumulator.
- P_ADDR_NBITS, 16, byte-address width.
- P_SIZE_NBITS, 14, width of the element count.
- P_MAX_INFLIGHT, 4, maximum outstanding memory reads (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- go  input  1  start pulse; sampled only in IDLE.
- base_addr  input  P_ADDR_NBITS  byte address of element 0; latched on accepted go.
- size  input  P_SIZE_NBITS  element count; latched on accepted go.
- mode  input  2  00 sum, 01 unsigned max, 10 unsigned min, 11 xor; latched on accepted go.
- busy  output  1  high in RUN and DONE.
- memreq_val  output  1  read request valid.
- memreq_rdy  input  1  memory accepts request.
- memreq_addr  output  P_ADDR_NBITS  request byte address.
- memresp_val  input  1  read data valid.
- memresp_rdy  output  1  block accepts response.
- memresp_data  input  P_DATA_NBITS  read data.
- result_val  output  1  result available.
- result_rdy  input  1  consumer accepts result.
- result  output  P_DATA_NBITS  reduction result.

Behaviour:
- Reset (async, rst=1): state=IDLE, and issue counter, receive counter, inflight counter, accumulator and latched regs all 0. All outputs 0.
- States: IDLE, RUN, DONE; registered FSM.
- IDLE:
  - go=1 latches base_addr, size and mode.
  - Accumulator loads the mode identity: 0 for sum, max and xor; all-ones for min.
  - Next state: RUN if size!=0, else DONE.
  - go outside IDLE is ignored.
- RUN:
  - memreq_val = (issued < size_q) && (inflight < P_MAX_INFLIGHT).
  - memreq_addr = base_q + (issued << 2), truncated to P_ADDR_NBITS (wraps).
  - A request fires on memreq_val & memreq_rdy: issued++, inflight++.
  - memresp_rdy=1 throughout RUN.
  - A response fires on memresp_val & memresp_rdy: acc <= op(acc, memresp_data), received++, inflight--.
  - Request fire and response fire in the same cycle leave inflight unchanged.
  - Responses are assumed in request order; the reduction is order-insensitive anyway.
  - Sum wraps modulo 2^P_DATA_NBITS. Max and min are unsigned compares.
  - RUN -> DONE in the cycle the size_q-th response fires. The last response is folded into acc in that same edge.
- DONE:
  - result_val=1, result=acc, held stable until result_rdy=1.
  - result_val & result_rdy -> IDLE next cycle.
  - A new go on the cycle after return is accepted.
- memresp_rdy=1 also in IDLE. Any response arriving in IDLE (stragglers after reset) is discarded and alters nothing. memresp_rdy=0 in DONE.
- Latency with memreq_rdy=1 and 1-cycle memory, size N, P_MAX_INFLIGHT>=2:
  - go at cycle 0.
  - First request at cycle 1.
  - Last response at cycle N+1.
  - result_val at cycle N+2.
- Boundaries:
  - size=0 gives result_val on the cycle after go, with result = mode identity.
  - Inflight saturates at P_MAX_INFLIGHT, and memreq_val drops even if memreq_rdy=1.
  - Reset during RUN or DONE aborts immediately; no result is produced.
  - result_rdy held low keeps DONE indefinitely with result stable.
  - The issue counter never exceeds size_q.
  - inflight, issued and received are P_SIZE_NBITS+1 bits wide, so size = 2^P_SIZE_NBITS-1 never overflows.

Test Plan:
1. Sum: mem[0x100..0x10C]={1,2,3,4}, base=0x100, size=4, mode=00, rdy always 1 -> addrs 0x100,0x104,0x108,0x10C in order; result=10 at cycle 6; busy drops after the result handshake.
2. Max/min/xor: data {5,0xFFFFFFFF,7} -> max=0xFFFFFFFF, min=5, xor=0xFFFFFFFD.
3. Inflight limit: P_MAX_INFLIGHT=2, memory delays responses 5 cycles, size=6 -> never more than 2 unanswered requests; sum correct.
4. Back-pressure: memreq_rdy random 50%, memresp_val random, result_rdy low for 10 cycles -> no lost or duplicated address; result_val and result held stable for 10 cycles; returns to IDLE 1 cycle after rdy.
5. size=0 with min mode -> result_val the cycle after go, result=0xFFFFFFFF; zero memreq_val cycles.
6. rst asserted mid-RUN (after 2 of 8 responses), then a late response arrives in IDLE -> outputs 0 immediately. A new go with size=3 on data {1,1,1} yields 3, unaffected by the straggler.
